cell_write_sequencer: RTL and testbench
=======================================

Name: cell_write_sequencer

Overview:
- Sequences all writes into the Sudoku board datapath during play.
- Two requesters share the single write port (wr_en/row/col/data into the solver):
  - the handwriting path: a completed mouse-drawn track launches the digit predictor, and the predicted digit is written;
  - the manual path: a switch digit plus a button pulse writes to the last selected cell.
- Owns the predictor start/finish handshake, the timeout, and the editable-cell check.

Parameters:
- PRED_TIMEOUT, 10_000_000, cycles to wait for pred_finish before abandoning (100 ms at 100 MHz).
- TO_W, 24, width of the timeout counter; must satisfy 2^TO_W > PRED_TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- game_active  in  1  high while the top-level FSM is in the game state.
- draw_valid  in  1  one-cycle pulse; the handwritten track is complete.
- draw_row  in  4  cell row of the drawn track, 0..8.
- draw_col  in  4  cell column of the drawn track, 0..8.
- sw_req  in  1  one-cycle pulse; manual write request (debounced, one-pulsed upstream).
- sw_data  in  4  manual digit.
- pred_start  out  1  one-cycle start pulse to the predictor.
- pred_finish  in  1  one-cycle pulse; pred_digit is valid.
- pred_digit  in  4  predicted digit.
- board_blank  in  81  bit row*9+col = 1 means the cell is player-editable.
- wr_en  out  1  one-cycle write strobe to the solver.
- wr_row  out  4  write row.
- wr_col  out  4  write column.
- wr_data  out  4  write digit.
- busy  out  1  high when state is not IDLE.
- reject  out  1  one-cycle pulse: request refused or timed out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - sel_valid=0, sel_row=sel_col=0.
  - sw_pending=0; timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, PRED_START, PRED_WAIT, CHECK, WRITE.
- IDLE, game_active=0: hold IDLE; ignore draw_valid and sw_req.
- IDLE, draw_valid=1:
  - latch cur_row/cur_col from draw_row/draw_col; copy the same values into sel_row/sel_col; set sel_valid=1;
  - go to PRED_START.
  - Draw has priority: a simultaneous sw_req is captured into sw_pending together with sw_data.
- IDLE, no draw_valid, (sw_req or sw_pending) and sel_valid=1:
  - cur = sel; digit = sw_data (or the pending data);
  - clear sw_pending; go to CHECK.
- IDLE, (sw_req or sw_pending) and sel_valid=0: pulse reject, clear sw_pending, stay in IDLE.
- PRED_START: pred_start=1 for exactly this cycle; clear the counter; go to PRED_WAIT.
- PRED_WAIT:
  - pred_finish=1: capture pred_digit; go to CHECK.
  - Otherwise the counter increments each cycle. At counter == PRED_TIMEOUT-1 without finish: pulse reject, go to IDLE.
  - pred_finish on the timeout cycle: finish wins.
- CHECK:
  - Accept when cur_row<9, cur_col<9, digit<=9 (0 = clear cell), and board_blank[cur_row*9+cur_col]=1. On accept, go to WRITE.
  - Otherwise pulse reject and go to IDLE.
- WRITE: wr_en=1 with wr_row/wr_col/wr_data = cur/digit for one cycle; go to IDLE.
  - wr_* retain their values after the strobe.
- Requests while busy:
  - sw_req sets sw_pending and overwrites pending data (one-deep; the latest wins).
  - draw_valid is dropped silently; sel is not updated.
- game_active falling in any non-IDLE state: abort to IDLE next cycle; no wr_en, no reject; clear sw_pending.
  - A pred_finish arriving later is ignored.
- Latency:
  - manual path: sw_req at cycle N gives wr_en at N+2;
  - draw path: draw_valid at N gives pred_start at N+1; pred_finish at M gives wr_en at M+2.
- Reset mid-operation: immediate return to reset values; no partial write is ever issued.

Decomposition:
- Package sudoku_pkg:
  - constants: GRID_N=9, DIGIT_W=4, CELL_IDX_W=7;
  - state enum for this FSM;
  - function cell_idx(row,col)=row*9+col.
- One sub-module, pred_timeout_timer: clear/enable inputs, PRED_TIMEOUT parameter, expired output.
- Everything else is inline.

Test Plan:
- Manual, no selection: after reset, sw_req with sw_data=5 -> reject pulse at N+1; no wr_en; busy stays 0.
- Handwriting path:
  - Stimulus: draw_valid at (row 2, col 3) with board_blank[21]=1; pred_finish with pred_digit=7 eight cycles after pred_start.
  - Response: pred_start one cycle after draw_valid; wr_en two cycles after pred_finish with row=2, col=3, data=7.
- Locked cell: select (4,4) by a draw; predictor returns 9; board_blank[40]=0 -> reject; no wr_en.
- Manual while busy: sw_req data=3, then data=6 during PRED_WAIT -> after the draw write, a second write to the same cell with data=6 (one only).
- Predictor timeout: PRED_TIMEOUT=16 and no pred_finish -> reject exactly 16 cycles after PRED_WAIT entry; IDLE.
- Abort and reset:
  - game_active drops during PRED_WAIT -> IDLE next cycle; a later pred_finish produces no wr_en.
  - rst_n low mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared Sudoku board constants, the write-sequencer state type and cell indexing.
package sudoku_pkg;

  localparam int unsigned GRID_N     = 9;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned CELL_IDX_W = 7;

  typedef enum logic [2:0] {
    StIdle,
    StPredStart,
    StPredWait,
    StCheck,
    StWrite
  } seq_state_e;

  // Linear board index; only meaningful for row, col < GRID_N.
  function automatic logic [CELL_IDX_W-1:0] cell_idx(input logic [DIGIT_W-1:0] row,
                                                     input logic [DIGIT_W-1:0] col);
    return CELL_IDX_W'(row) * CELL_IDX_W'(GRID_N) + CELL_IDX_W'(col);
  endfunction

endpackage

// File: rtl/pred_timeout_timer.sv
// Cycle counter bounding how long the sequencer waits on the digit predictor.
module pred_timeout_timer #(
  parameter int unsigned PRED_TIMEOUT = 10_000_000,
  parameter int unsigned TO_W         = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == TO_W'(PRED_TIMEOUT - 1));

endmodule

// File: rtl/cell_write_sequencer.sv
// Arbitrates handwriting and manual digit writes onto the single board write port.
module cell_write_sequencer
  import sudoku_pkg::*;
#(
  parameter int unsigned PRED_TIMEOUT = 10_000_000,
  parameter int unsigned TO_W         = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic        draw_valid,
  input  logic [3:0]  draw_row,
  input  logic [3:0]  draw_col,
  input  logic        sw_req,
  input  logic [3:0]  sw_data,
  output logic        pred_start,
  input  logic        pred_finish,
  input  logic [3:0]  pred_digit,
  input  logic [80:0] board_blank,
  output logic        wr_en,
  output logic [3:0]  wr_row,
  output logic [3:0]  wr_col,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic        reject
);

  seq_state_e   state_q;
  logic         sel_valid_q;
  logic [3:0]   sel_row_q, sel_col_q;
  logic [3:0]   cur_row_q, cur_col_q, digit_q;
  logic         sw_pending_q;
  logic [3:0]   pend_data_q;
  logic         expired;
  logic         accept;

  pred_timeout_timer #(
    .PRED_TIMEOUT (PRED_TIMEOUT),
    .TO_W         (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == StPredStart),
    .enable  (state_q == StPredWait),
    .expired (expired)
  );

  assign accept = (cur_row_q < 4'(GRID_N)) && (cur_col_q < 4'(GRID_N)) && (digit_q <= 4'd9) &&
                  board_blank[cell_idx(cur_row_q, cur_col_q)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_valid_q  <= 1'b0;
      sel_row_q    <= '0;
      sel_col_q    <= '0;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      digit_q      <= '0;
      sw_pending_q <= 1'b0;
      pend_data_q  <= '0;
      pred_start   <= 1'b0;
      wr_en        <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      reject       <= 1'b0;
    end else begin
      pred_start <= 1'b0;
      wr_en      <= 1'b0;
      reject     <= 1'b0;

      // One-deep manual request buffer while an operation is in flight; latest wins.
      if (state_q != StIdle && sw_req) begin
        sw_pending_q <= 1'b1;
        pend_data_q  <= sw_data;
      end

      if (state_q != StIdle && !game_active) begin
        state_q      <= StIdle;
        busy         <= 1'b0;
        sw_pending_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (game_active) begin
              if (draw_valid) begin
                cur_row_q   <= draw_row;
                cur_col_q   <= draw_col;
                sel_row_q   <= draw_row;
                sel_col_q   <= draw_col;
                sel_valid_q <= 1'b1;
                state_q     <= StPredStart;
                pred_start  <= 1'b1;
                busy        <= 1'b1;
                if (sw_req) begin
                  sw_pending_q <= 1'b1;
                  pend_data_q  <= sw_data;
                end
              end else if (sw_req || sw_pending_q) begin
                sw_pending_q <= 1'b0;
                if (sel_valid_q) begin
                  cur_row_q <= sel_row_q;
                  cur_col_q <= sel_col_q;
                  digit_q   <= sw_req ? sw_data : pend_data_q;
                  state_q   <= StCheck;
                  busy      <= 1'b1;
                end else begin
                  reject <= 1'b1;
                end
              end
            end
          end
          StPredStart: state_q <= StPredWait;
          StPredWait: begin
            if (pred_finish) begin
              digit_q <= pred_digit;
              state_q <= StCheck;
            end else if (expired) begin
              reject  <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
          StCheck: begin
            if (accept) begin
              state_q <= StWrite;
              wr_en   <= 1'b1;
              wr_row  <= cur_row_q;
              wr_col  <= cur_col_q;
              wr_data <= digit_q;
            end else begin
              reject  <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
          StWrite: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_write_sequencer.sv
// Directed bench for cell_write_sequencer with hand-computed cycle expectations.
module tb_cell_write_sequencer;

  logic        clk;
  logic        rst_n;
  logic        game_active;
  logic        draw_valid;
  logic [3:0]  draw_row, draw_col;
  logic        sw_req;
  logic [3:0]  sw_data;
  logic        pred_start;
  logic        pred_finish;
  logic [3:0]  pred_digit;
  logic [80:0] board_blank;
  logic        wr_en;
  logic [3:0]  wr_row, wr_col, wr_data;
  logic        busy;
  logic        reject;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr_base;

  cell_write_sequencer #(
    .PRED_TIMEOUT (16),
    .TO_W         (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_active (game_active),
    .draw_valid  (draw_valid),
    .draw_row    (draw_row),
    .draw_col    (draw_col),
    .sw_req      (sw_req),
    .sw_data     (sw_data),
    .pred_start  (pred_start),
    .pred_finish (pred_finish),
    .pred_digit  (pred_digit),
    .board_blank (board_blank),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .busy        (busy),
    .reject      (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle; every simulated cycle passes through here once.
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en) wr_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse draw_valid; returns in the first PRED_WAIT cycle.
  task automatic draw(input logic [3:0] r, input logic [3:0] c);
    draw_row   = r;
    draw_col   = c;
    draw_valid = 1'b1;
    step();
    draw_valid = 1'b0;
    chk("draw_pred_start", pred_start, 1);
    step();
  endtask

  task automatic finish_pred(input logic [3:0] d);
    pred_finish = 1'b1;
    pred_digit  = d;
    step();
    pred_finish = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    game_active = 1'b0;
    draw_valid  = 1'b0;
    draw_row    = '0;
    draw_col    = '0;
    sw_req      = 1'b0;
    sw_data     = '0;
    pred_finish = 1'b0;
    pred_digit  = '0;
    board_blank = '1;
    board_blank[40] = 1'b0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_outs", {pred_start, reject, wr_row, wr_col, wr_data}, 0);
    step();
    rst_n       = 1'b1;
    game_active = 1'b1;
    step();

    // Manual request with no selection is refused the next cycle.
    sw_req  = 1'b1;
    sw_data = 4'd5;
    step();
    sw_req = 1'b0;
    chk("nosel_reject", reject, 1);
    chk("nosel_busy", busy, 0);
    chk("nosel_wr_en", wr_en, 0);
    step();
    chk("nosel_reject_clr", reject, 0);

    // Handwriting path: finish eight cycles after pred_start.
    draw(4'd2, 4'd3);
    chk("hw_start_pulse", pred_start, 0);
    chk("hw_busy", busy, 1);
    steps(7);
    finish_pred(4'd7);
    chk("hw_wr_early", wr_en, 0);
    step();
    chk("hw_wr_en", wr_en, 1);
    chk("hw_wr_addr", {wr_row, wr_col, wr_data}, {4'd2, 4'd3, 4'd7});
    step();
    chk("hw_wr_done", wr_en, 0);
    chk("hw_wr_hold", wr_data, 7);
    chk("hw_idle", busy, 0);

    // Locked cell (4,4) -> index 40 is not editable.
    wr_base = wr_cnt;
    draw(4'd4, 4'd4);
    finish_pred(4'd9);
    step();
    chk("lock_reject", reject, 1);
    chk("lock_nowr", wr_cnt - wr_base, 0);

    // Out-of-range row is refused.
    wr_base = wr_cnt;
    draw(4'd9, 4'd0);
    finish_pred(4'd1);
    step();
    chk("range_reject", reject, 1);
    chk("range_nowr", wr_cnt - wr_base, 0);

    // Two manual requests while busy; only the latest is written after the draw.
    wr_base    = wr_cnt;
    draw_row   = 4'd2;
    draw_col   = 4'd3;
    draw_valid = 1'b1;
    step();
    draw_valid = 1'b0;
    sw_req     = 1'b1;
    sw_data    = 4'd3;
    step();
    sw_req = 1'b0;
    step();
    sw_req  = 1'b1;
    sw_data = 4'd6;
    step();
    sw_req = 1'b0;
    finish_pred(4'd1);
    step();
    chk("busy_wr1", {wr_en, wr_data}, {1'b1, 4'd1});
    steps(3);
    chk("busy_wr2", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 4'd2, 4'd3, 4'd6});
    steps(5);
    chk("busy_wr_count", wr_cnt - wr_base, 2);

    // Timeout: reject exactly 16 cycles after PRED_WAIT entry.
    draw(4'd2, 4'd3);
    steps(15);
    chk("to_not_yet", {reject, busy}, {1'b0, 1'b1});
    step();
    chk("to_reject", {reject, busy}, {1'b1, 1'b0});

    // Abort on game_active fall; a late pred_finish is ignored.
    step();
    wr_base = wr_cnt;
    draw(4'd2, 4'd3);
    game_active = 1'b0;
    step();
    chk("abort_idle", {busy, reject}, 0);
    game_active = 1'b1;
    finish_pred(4'd5);
    steps(4);
    chk("abort_nowr", wr_cnt - wr_base, 0);
    chk("abort_busy", busy, 0);

    // Asynchronous reset in the middle of PRED_WAIT.
    draw(4'd2, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {pred_start, wr_en, busy, reject, wr_row, wr_col, wr_data}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_stay", {busy, wr_en}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
